tt_adder_pipe: RTL and testbench

//  Parametrised, two-stage pipelined adder/accumulator replacing the combinational ui_in+uio_in datapath.

---
 rtl/tt_adder_pipe.sv | 138 +++++++++++++
 tb/tb_tt_adder_pipe.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_adder_pipe.sv
// Two-stage pipelined adder/accumulator with wrap/saturate/accumulate modes.
// Stage 1 captures operands; stage 2 computes, accumulates and holds the result.
module tt_adder_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             ovf_sticky
);

  typedef enum logic [1:0] {
    M_ADD     = 2'd0,
    M_SAT     = 2'd1,
    M_ACC     = 2'd2,
    M_ACC_SAT = 2'd3
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    mode_e            mode;
    logic             clear;
  } s1_t;

  s1_t              s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;

  logic             s2_free;
  logic             adv;
  logic             in_fire;
  logic             out_fire;
  logic             is_acc;
  logic             is_sat;
  logic [WIDTH-1:0] base;
  logic [WIDTH+1:0] full;
  logic             ovf;
  logic [WIDTH-1:0] res;

  assign s2_free  = !out_valid_q || out_ready;
  assign adv      = ena && s1_valid_q && s2_free;
  assign in_ready = ena && (!s1_valid_q || s2_free);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = ena && out_valid_q && out_ready;

  always_comb begin
    is_acc = 1'b0;
    is_sat = 1'b0;
    unique case (s1_q.mode)
      M_ADD:     begin is_acc = 1'b0; is_sat = 1'b0; end
      M_SAT:     begin is_acc = 1'b0; is_sat = 1'b1; end
      M_ACC:     begin is_acc = 1'b1; is_sat = 1'b0; end
      M_ACC_SAT: begin is_acc = 1'b1; is_sat = 1'b1; end
      default:   begin is_acc = 1'b0; is_sat = 1'b0; end
    endcase
  end

  // Two extra bits hold the carry of acc + a + b without loss.
  assign base = (is_acc && !s1_q.clear) ? acc_q : '0;
  assign full = {2'b00, base} + {2'b00, s1_q.a} + {2'b00, s1_q.b};
  assign ovf  = |full[WIDTH+1:WIDTH];
  assign res  = (is_sat && ovf) ? {WIDTH{1'b1}} : full[WIDTH-1:0];

  always_comb begin
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;

    if (in_fire) begin
      s1_d.a     = in_a;
      s1_d.b     = in_b;
      s1_d.mode  = mode_e'(in_mode);
      s1_d.clear = in_clear;
      s1_valid_d = 1'b1;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end

    if (adv) begin
      out_valid_d = 1'b1;
      sum_d       = res;
      ovf_d       = ovf;
      sticky_d    = (s1_q.clear ? 1'b0 : sticky_q) | ovf;
      if (is_acc) begin
        acc_d = res;
      end else if (s1_q.clear) begin
        acc_d = '0;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = sum_q;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_tt_adder_pipe.sv
// Randomised and directed bench for tt_adder_pipe against an arithmetic model.
// Each scenario task checks its own observations inline.
module tb_tt_adder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_mode;
  logic       in_clear;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       ovf_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] sum;
    logic       ovf;
    logic       st;
  } exp_t;

  exp_t q[$];
  int   m_acc = 0;
  bit   m_st  = 0;

  always #5 clk = ~clk;

  tt_adder_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_clear  (in_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .ovf_sticky(ovf_sticky)
  );

  // Results are produced in acceptance order, so the model runs at accept time.
  function automatic exp_t model(int a, int b, int m, bit c);
    exp_t e;
    int   base;
    int   s;
    int   r;
    bit   ov;
    base = (m >= 2) ? (c ? 0 : m_acc) : 0;
    s    = base + a + b;
    ov   = (s >= 256);
    if (m == 1 || m == 3) r = ov ? 255 : s;
    else                  r = s % 256;
    if (m >= 2)  m_acc = r;
    else if (c)  m_acc = 0;
    m_st  = (c ? 1'b0 : m_st) | ov;
    e.sum = r[7:0];
    e.ovf = ov;
    e.st  = m_st;
    return e;
  endfunction

  task automatic drive(bit v, int a, int b, int m, bit c);
    in_valid = v;
    in_a     = a[7:0];
    in_b     = b[7:0];
    in_mode  = m[1:0];
    in_clear = c;
  endtask

  task automatic tick(output bit af, output bit got, output logic [7:0] s,
                      output logic o, output logic st, output logic ir);
    @(negedge clk);
    ir  = in_ready;
    af  = in_valid && in_ready;
    got = out_valid && out_ready && ena;
    s   = out_sum;
    o   = out_ovf;
    st  = ovf_sticky;
    if (af) q.push_back(model(in_a, in_b, in_mode, in_clear));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", out_sum); end
    n_checks++;
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
    n_checks++;
    if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %b want 0", ovf_sticky); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add_latency();
    bit af, g;
    logic [7:0] s;
    logic o, st, ir;
    exp_t e;
    out_ready = 1'b1;
    drive(1, 8'h12, 8'h34, 0, 0);
    tick(af, g, s, o, st, ir);
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (af !== 1'b1) begin n_fail++; $display("FAIL lat_accept got %b want 1", af); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early got %b want 0", out_valid); end
    tick(af, g, s, o, st, ir);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'h46 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_result got v=%b sum=%h ovf=%b want v=1 sum=46 ovf=0", out_valid, out_sum, out_ovf);
    end
    tick(af, g, s, o, st, ir);
    if (g) e = q.pop_front();
    n_checks++;
    if (g !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_drain got xfer=%b v=%b want xfer=1 v=0", g, out_valid);
    end
  endtask

  task automatic test_ovf_sat();
    bit af, g;
    logic [7:0] s;
    logic o, st, ir;
    exp_t e;
    logic [7:0] es[2] = '{8'h10, 8'hFF};
    int k = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      drive(1, 8'hF0, 8'h20, 0, 0);
      else if (i == 1) drive(1, 8'hF0, 8'h20, 1, 0);
      else             drive(0, 0, 0, 0, 0);
      tick(af, g, s, o, st, ir);
      if (g && k < 2) begin
        e = q.pop_front();
        n_checks++;
        if (s !== es[k] || o !== 1'b1 || st !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_sat[%0d] got sum=%h ovf=%b st=%b want sum=%h ovf=1 st=1", k, s, o, st, es[k]);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 2) begin n_fail++; $display("FAIL ovf_sat_count got %0d want 2", k); end
  endtask

  task automatic test_acc_stream();
    bit af, g;
    logic [7:0] s;
    logic o, st, ir;
    exp_t e;
    logic [7:0] es[3] = '{8'd3, 8'd10, 8'd21};
    int k = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) drive(1, 2 * i + 1, 2 * i + 2, 2, i == 0);
      else       drive(0, 0, 0, 0, 0);
      tick(af, g, s, o, st, ir);
      if (i < 3) begin
        n_checks++;
        if (ir !== 1'b1) begin n_fail++; $display("FAIL acc_ready[%0d] got %b want 1", i, ir); end
      end
      if (g && k < 3) begin
        e = q.pop_front();
        n_checks++;
        if (s !== es[k] || o !== 1'b0) begin
          n_fail++;
          $display("FAIL acc_stream[%0d] got sum=%0d ovf=%b want sum=%0d ovf=0", k, s, o, es[k]);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 3) begin n_fail++; $display("FAIL acc_count got %0d want 3", k); end
  endtask

  task automatic test_acc_sat();
    bit af, g;
    logic [7:0] s;
    logic o, st, ir;
    exp_t e;
    logic [7:0] es[3] = '{8'hF0, 8'hFF, 8'h01};
    logic       eo[3] = '{1'b0, 1'b1, 1'b0};
    logic       est[3] = '{1'b0, 1'b1, 1'b0};
    int k = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      drive(1, 8'hF0, 8'h00, 2, 1);
      else if (i == 1) drive(1, 8'h10, 8'h05, 3, 0);
      else if (i == 2) drive(1, 8'h01, 8'h00, 3, 1);
      else             drive(0, 0, 0, 0, 0);
      tick(af, g, s, o, st, ir);
      if (g && k < 3) begin
        e = q.pop_front();
        n_checks++;
        if (s !== es[k] || o !== eo[k] || st !== est[k]) begin
          n_fail++;
          $display("FAIL acc_sat[%0d] got sum=%h ovf=%b st=%b want sum=%h ovf=%b st=%b",
                   k, s, o, st, es[k], eo[k], est[k]);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 3) begin n_fail++; $display("FAIL acc_sat_count got %0d want 3", k); end
  endtask

  task automatic test_stall();
    bit af, g;
    logic [7:0] s;
    logic o, st, ir;
    exp_t e;
    int ia[3] = '{8'h11, 8'h33, 8'h55};
    int ib[3] = '{8'h22, 8'h44, 8'h66};
    logic [7:0] es[3] = '{8'h33, 8'h77, 8'hBB};
    int idx = 0;
    int k = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, ia[idx], ib[idx], 0, 0);
      tick(af, g, s, o, st, ir);
      if (af) idx++;
      if (i >= 2) begin
        n_checks++;
        if (s !== 8'h33 || ir !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold[%0d] got sum=%h rdy=%b want sum=33 rdy=0", i, s, ir);
        end
      end
    end
    n_checks++;
    if (idx != 2) begin n_fail++; $display("FAIL stall_accepted got %0d want 2", idx); end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (idx < 3) drive(1, ia[idx], ib[idx], 0, 0);
      else         drive(0, 0, 0, 0, 0);
      tick(af, g, s, o, st, ir);
      if (af) idx++;
      if (g) begin
        if (q.size() > 0) e = q.pop_front();
        n_checks++;
        if (k >= 3 || s !== es[k]) begin
          n_fail++;
          $display("FAIL stall_order[%0d] got sum=%h want %h", k, s, (k < 3) ? es[k] : 8'hxx);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 3) begin n_fail++; $display("FAIL stall_count got %0d want 3", k); end
  endtask

  task automatic test_ena_freeze();
    bit af, g;
    logic [7:0] s;
    logic o, st, ir;
    exp_t e;
    int k = 0;
    out_ready = 1'b0;
    drive(1, 1, 2, 0, 0);
    tick(af, g, s, o, st, ir);
    drive(0, 0, 0, 0, 0);
    tick(af, g, s, o, st, ir);
    ena = 1'b0;
    out_ready = 1'b1;
    drive(1, 5, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(af, g, s, o, st, ir);
      n_checks++;
      if (g !== 1'b0 || af !== 1'b0 || ir !== 1'b0 || s !== 8'd3 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ena_freeze[%0d] got xfer=%b acc=%b rdy=%b sum=%h v=%b want 0 0 0 03 1",
                 i, g, af, ir, s, out_valid);
      end
    end
    drive(0, 0, 0, 0, 0);
    ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(af, g, s, o, st, ir);
      if (g) begin
        if (q.size() > 0) e = q.pop_front();
        n_checks++;
        if (s !== 8'd3) begin n_fail++; $display("FAIL ena_result got %h want 03", s); end
        k++;
      end
    end
    n_checks++;
    if (k != 1) begin n_fail++; $display("FAIL ena_count got %0d want 1", k); end
  endtask

  task automatic test_reset_mid();
    bit af, g;
    logic [7:0] s;
    logic o, st, ir;
    exp_t e;
    int k = 0;
    out_ready = 1'b0;
    drive(1, 9, 9, 2, 1);
    tick(af, g, s, o, st, ir);
    drive(1, 2, 2, 2, 0);
    tick(af, g, s, o, st, ir);
    drive(0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_ovf !== 1'b0 || ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got v=%b sum=%h ovf=%b st=%b want 0 00 0 0", out_valid, out_sum, out_ovf, ovf_sticky);
    end
    q.delete();
    m_acc = 0;
    m_st = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1, 7, 0, 2, 0);
      else        drive(0, 0, 0, 0, 0);
      tick(af, g, s, o, st, ir);
      if (g) begin
        if (q.size() > 0) e = q.pop_front();
        n_checks++;
        if (s !== 8'd7) begin n_fail++; $display("FAIL rst_acc got %h want 07", s); end
        k++;
      end
    end
    n_checks++;
    if (k != 1) begin n_fail++; $display("FAIL rst_count got %0d want 1", k); end
  endtask

  task automatic test_random();
    bit af, g;
    logic [7:0] s;
    logic o, st, ir;
    exp_t e;
    for (int i = 0; i < 600; i++) begin
      ena = ($urandom % 8) != 0;
      out_ready = ($urandom % 4) != 0;
      drive(($urandom % 4) != 0, (($urandom % 2) != 0) ? int'($urandom_range(192, 255)) : int'($urandom % 256),
            $urandom % 256, $urandom % 4, ($urandom % 6) == 0);
      tick(af, g, s, o, st, ir);
      if (g) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra got sum=%h want no output", s);
        end else begin
          e = q.pop_front();
          if (s !== e.sum || o !== e.ovf || st !== e.st) begin
            n_fail++;
            $display("FAIL rand[%0d] got sum=%h ovf=%b st=%b want sum=%h ovf=%b st=%b",
                     i, s, o, st, e.sum, e.ovf, e.st);
          end
        end
      end
    end
    ena = 1'b1;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      tick(af, g, s, o, st, ir);
      if (g) begin
        e = q.pop_front();
        n_checks++;
        if (s !== e.sum || o !== e.ovf || st !== e.st) begin
          n_fail++;
          $display("FAIL rand_drain got sum=%h ovf=%b st=%b want sum=%h ovf=%b st=%b",
                   s, o, st, e.sum, e.ovf, e.st);
        end
      end
    end
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL rand_timeout got %0d pending want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_ovf_sat();
    test_acc_stream();
    test_acc_sat();
    test_stall();
    test_ena_freeze();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
